// File: rtl/ysyx_25060170_pkg.sv
// ----------------------------------------------------------------------------
// ysyx_25060170_pkg : shared control-FSM state encodings and RV32 opcodes
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package ysyx_25060170_pkg;

   localparam int STATE_W = 3;

   // Code 7 is deliberately unused; the FSM steers it back to IDLE.
   typedef enum logic [STATE_W-1:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_DECODE = 3'd2,
      ST_MEM    = 3'd3,
      ST_WB     = 3'd4,
      ST_HALT   = 3'd5,
      ST_ERR    = 3'd6
   } state_t;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

   function automatic logic is_bus_wait(input state_t s);
      return (s == ST_FETCH) || (s == ST_MEM);
   endfunction

endpackage

`default_nettype wire

// File: rtl/ysyx_25060170_wdt.sv
// ----------------------------------------------------------------------------
// ysyx_25060170_wdt : bus-ack watchdog; expired pulses on the TIMEOUT-th wait
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module ysyx_25060170_wdt #(
   parameter int TIMEOUT = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
   localparam int LIMIT = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
   localparam logic [CNT_W-1:0] LIMIT_V = CNT_W'(LIMIT);
   localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

   logic [CNT_W-1:0] count;

   // Saturating so a disabled watchdog never wraps back to a stale match.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (en && (count != '1)) begin
         count <= count + ONE;
      end
   end

   // Fires in the wait cycle that brings the count up to TIMEOUT.
   assign expired = (TIMEOUT != 0) && en && (count == LIMIT_V);

endmodule

`default_nettype wire

// File: rtl/ysyx_25060170_ctrl.sv
// ----------------------------------------------------------------------------
// ysyx_25060170_ctrl : multi-cycle core control FSM (fetch/decode/mem/wb)
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module ysyx_25060170_ctrl
   import ysyx_25060170_pkg::*;
#(
   parameter int TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   output logic        ifu_req_o,
   input  logic        ifu_ack_i,
   input  logic [31:0] ifu_rdata_i,
   output logic [31:0] inst_o,
   input  logic        is_load_i,
   input  logic        is_store_i,
   input  logic        is_ebreak_i,
   input  logic        reg_we_i,
   output logic        lsu_req_o,
   input  logic        lsu_ack_i,
   output logic        gpr_we_o,
   output logic        pc_we_o,
   output logic        halt_o,
   output logic        timeout_o,
   output logic [31:0] instret_o,
   output logic [2:0]  state_o
);

   state_t state;
   state_t next_state;
   logic   wdt_clr;
   logic   wdt_en;
   logic   wdt_expired;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         inst_o <= 32'd0;
      end else if ((state == ST_FETCH) && ifu_ack_i) begin
         inst_o <= ifu_rdata_i;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         instret_o <= 32'd0;
      end else if (state == ST_WB) begin
         instret_o <= instret_o + 32'd1;
      end
   end

   // An ack always beats the watchdog in the same cycle.
   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE:   next_state = ST_FETCH;
         ST_FETCH: begin
            if (ifu_ack_i) begin
               next_state = ST_DECODE;
            end else if (wdt_expired) begin
               next_state = ST_ERR;
            end
         end
         ST_DECODE: begin
            if (is_ebreak_i) begin
               next_state = ST_HALT;
            end else if (is_load_i || is_store_i) begin
               next_state = ST_MEM;
            end else begin
               next_state = ST_WB;
            end
         end
         ST_MEM: begin
            if (lsu_ack_i) begin
               next_state = ST_WB;
            end else if (wdt_expired) begin
               next_state = ST_ERR;
            end
         end
         ST_WB:     next_state = ST_FETCH;
         ST_HALT:   next_state = ST_HALT;
         ST_ERR:    next_state = ST_ERR;
         default:   next_state = ST_IDLE;
      endcase
   end

   // Held clear outside the wait states, so every FETCH/MEM entry starts at 0.
   always_comb begin
      wdt_clr = !is_bus_wait(state);
      wdt_en  = ((state == ST_FETCH) && !ifu_ack_i) ||
                ((state == ST_MEM)   && !lsu_ack_i);
   end

   ysyx_25060170_wdt #(
      .TIMEOUT (TIMEOUT)
   ) u_wdt (
      .clk     (clk),
      .rst     (rst),
      .clr     (wdt_clr),
      .en      (wdt_en),
      .expired (wdt_expired)
   );

   assign ifu_req_o = (state == ST_FETCH);
   assign lsu_req_o = (state == ST_MEM);
   assign pc_we_o   = (state == ST_WB);
   assign gpr_we_o  = (state == ST_WB) && reg_we_i;
   assign halt_o    = (state == ST_HALT);
   assign timeout_o = (state == ST_ERR);
   assign state_o   = state;

endmodule

`default_nettype wire

// File: tb/tb_ysyx_25060170_ctrl.sv
// ----------------------------------------------------------------------------
// tb_ysyx_25060170_ctrl : randomized scoreboard bench for the control FSM
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_ysyx_25060170_ctrl;

   localparam int K_RET  = 0;
   localparam int K_HALT = 1;
   localparam int K_ERR  = 2;

   logic        clk;
   logic        rst;
   logic        ifu_req_o;
   logic        ifu_ack_i;
   logic [31:0] ifu_rdata_i;
   logic [31:0] inst_o;
   logic        is_load_i;
   logic        is_store_i;
   logic        is_ebreak_i;
   logic        reg_we_i;
   logic        lsu_req_o;
   logic        lsu_ack_i;
   logic        gpr_we_o;
   logic        pc_we_o;
   logic        halt_o;
   logic        timeout_o;
   logic [31:0] instret_o;
   logic [2:0]  state_o;

   typedef struct {
      int          kind;
      logic [31:0] inst;
      logic        gpr_we;
      logic [31:0] instret;
      int          lat;
      int          lsu_n;
   } exp_t;

   exp_t        exp_q[$];
   exp_t        mon_e;
   int          checks;
   int          errors;
   int          model_instret;
   int          cyc;
   int          start_cyc;
   int          lsu_cnt;
   logic        prev_req;
   logic        prev_halt;
   logic        prev_to;

   ysyx_25060170_ctrl #(
      .TIMEOUT (4)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .ifu_req_o   (ifu_req_o),
      .ifu_ack_i   (ifu_ack_i),
      .ifu_rdata_i (ifu_rdata_i),
      .inst_o      (inst_o),
      .is_load_i   (is_load_i),
      .is_store_i  (is_store_i),
      .is_ebreak_i (is_ebreak_i),
      .reg_we_i    (reg_we_i),
      .lsu_req_o   (lsu_req_o),
      .lsu_ack_i   (lsu_ack_i),
      .gpr_we_o    (gpr_we_o),
      .pc_we_o     (pc_we_o),
      .halt_o      (halt_o),
      .timeout_o   (timeout_o),
      .instret_o   (instret_o),
      .state_o     (state_o)
   );

   always #5 clk = ~clk;

   // Stand-in for the IDU: combinational decode of the instruction register.
   assign is_load_i   = (inst_o[6:0] == 7'b0000011);
   assign is_store_i  = (inst_o[6:0] == 7'b0100011);
   assign is_ebreak_i = (inst_o == 32'h0010_0073);
   always_comb begin
      reg_we_i = 1'b0;
      case (inst_o[6:0])
         7'b0010011, 7'b0110011, 7'b0000011, 7'b0110111,
         7'b0010111, 7'b1101111, 7'b1100111: reg_we_i = 1'b1;
         default:                            reg_we_i = 1'b0;
      endcase
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ifu();
      int n = 0;
      while (!ifu_req_o && n < 20) begin
         ifu_ack_i   = 1'($urandom_range(0, 1));
         ifu_rdata_i = $urandom();
         lsu_ack_i   = 1'($urandom_range(0, 1));
         step();
         n++;
      end
      check("ifu_req_seen", {31'd0, ifu_req_o}, 32'd1);
   endtask

   task automatic wait_lsu();
      int n = 0;
      while (!lsu_req_o && n < 20) begin
         ifu_ack_i   = 1'($urandom_range(0, 1));
         ifu_rdata_i = $urandom();
         lsu_ack_i   = 1'($urandom_range(0, 1));
         step();
         n++;
      end
      check("lsu_req_seen", {31'd0, lsu_req_o}, 32'd1);
   endtask

   task automatic fetch(input logic [31:0] inst, input int fw);
      wait_ifu();
      for (int i = 0; i < fw; i++) begin
         ifu_ack_i   = 1'b0;
         ifu_rdata_i = $urandom();
         lsu_ack_i   = 1'($urandom_range(0, 1));
         step();
      end
      ifu_ack_i   = 1'b1;
      ifu_rdata_i = inst;
      lsu_ack_i   = 1'($urandom_range(0, 1));
      step();
      ifu_ack_i   = 1'($urandom_range(0, 1));
      ifu_rdata_i = $urandom();
   endtask

   task automatic serve_mem(input int mw);
      wait_lsu();
      for (int i = 0; i < mw; i++) begin
         lsu_ack_i   = 1'b0;
         ifu_ack_i   = 1'($urandom_range(0, 1));
         ifu_rdata_i = $urandom();
         step();
      end
      lsu_ack_i = 1'b1;
      step();
      lsu_ack_i = 1'($urandom_range(0, 1));
   endtask

   // Expected retire: FETCH(fw+1) + DECODE + [MEM(mw+1)] + WB.
   task automatic issue(input logic [31:0] inst, input bit mem, input bit wr,
                        input int fw, input int mw);
      exp_t e;
      e.kind    = K_RET;
      e.inst    = inst;
      e.gpr_we  = wr;
      e.instret = model_instret;
      e.lat     = fw + 3 + (mem ? mw + 1 : 0);
      e.lsu_n   = mem ? mw + 1 : 0;
      exp_q.push_back(e);
      fetch(inst, fw);
      if (mem) serve_mem(mw);
      model_instret++;
   endtask

   task automatic push_event(input int kind, input int lat);
      exp_t e;
      e.kind    = kind;
      e.inst    = 32'd0;
      e.gpr_we  = 1'b0;
      e.instret = model_instret;
      e.lat     = lat;
      e.lsu_n   = 0;
      exp_q.push_back(e);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #1;
      check("rst_state",   {29'd0, state_o}, 32'd0);
      check("rst_inst",    inst_o, 32'd0);
      check("rst_instret", instret_o, 32'd0);
      check("rst_outputs", {26'd0, ifu_req_o, lsu_req_o, gpr_we_o, pc_we_o, halt_o, timeout_o}, 32'd0);
      @(posedge clk);
      @(posedge clk);
      #1;
      exp_q.delete();
      model_instret = 0;
      ifu_ack_i     = 1'b0;
      lsu_ack_i     = 1'b0;
      rst           = 1'b0;
      check("idle_no_req", {31'd0, ifu_req_o}, 32'd0);
      step();
      check("first_req_2nd_cycle", {31'd0, ifu_req_o}, 32'd1);
   endtask

   always @(negedge clk) begin
      if (rst) begin
         prev_req  = 1'b0;
         prev_halt = 1'b0;
         prev_to   = 1'b0;
         lsu_cnt   = 0;
      end else begin
         cyc++;
         if (ifu_req_o && !prev_req) begin
            start_cyc = cyc;
            lsu_cnt   = 0;
         end
         if (lsu_req_o) lsu_cnt++;
         check("gpr_we_outside_wb", {31'd0, gpr_we_o & ~pc_we_o}, 32'd0);
         if (pc_we_o || (halt_o && !prev_halt) || (timeout_o && !prev_to)) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_event: pc_we=%0b halt=%0b timeout=%0b, expected none",
                        pc_we_o, halt_o, timeout_o);
            end else begin
               mon_e = exp_q.pop_front();
               check("event_kind", pc_we_o ? K_RET : (halt_o ? K_HALT : K_ERR), mon_e.kind);
               check("latency", cyc - start_cyc + 1, mon_e.lat);
               check("instret", instret_o, mon_e.instret);
               if (mon_e.kind == K_RET) begin
                  check("inst", inst_o, mon_e.inst);
                  check("gpr_we", {31'd0, gpr_we_o}, {31'd0, mon_e.gpr_we});
                  check("lsu_req_cycles", lsu_cnt, mon_e.lsu_n);
               end
            end
         end
         prev_req  = ifu_req_o;
         prev_halt = halt_o;
         prev_to   = timeout_o;
      end
   end

   initial begin
      logic [31:0] r;
      logic [6:0]  opc;
      int          cls;
      int          n;
      clk = 1'b0; rst = 1'b0;
      ifu_ack_i = 1'b0; ifu_rdata_i = 32'd0; lsu_ack_i = 1'b0;
      checks = 0; errors = 0; model_instret = 0; cyc = 0; start_cyc = 0;
      #2;
      do_reset();

      issue(32'h0050_0093, 1'b0, 1'b1, 0, 0);   // addi, immediate ack
      issue(32'h0000_a103, 1'b1, 1'b1, 2, 3);   // lw, 2 imem + 3 dmem waits
      issue(32'h0020_a023, 1'b1, 1'b0, 0, 0);   // sw
      issue(32'h0040_a183, 1'b1, 1'b1, 3, 3);   // acks land on the timeout cycle

      for (int k = 0; k < 40; k++) begin
         r   = $urandom();
         cls = $urandom_range(0, 5);
         case (cls)
            0:       opc = 7'b0010011;
            1:       opc = 7'b0110011;
            2:       opc = 7'b0000011;
            3:       opc = 7'b0100011;
            4:       opc = 7'b1100011;
            default: opc = 7'b0110111;
         endcase
         issue({r[31:7], opc}, (cls == 2) || (cls == 3), (cls != 3) && (cls != 4),
               $urandom_range(0, 3), $urandom_range(0, 3));
      end

      n = $urandom_range(0, 3);
      push_event(K_HALT, n + 3);
      fetch(32'h0010_0073, n);
      repeat (6) begin
         ifu_ack_i = 1'($urandom_range(0, 1));
         lsu_ack_i = 1'($urandom_range(0, 1));
         step();
      end
      check("halt_sticky", {31'd0, halt_o}, 32'd1);
      check("halt_instret", instret_o, model_instret);
      check("halt_no_req", {30'd0, ifu_req_o, lsu_req_o}, 32'd0);
      do_reset();

      push_event(K_ERR, 5);
      wait_ifu();
      repeat (8) begin
         ifu_ack_i = 1'b0;
         lsu_ack_i = 1'($urandom_range(0, 1));
         step();
      end
      check("fetch_timeout_sticky", {31'd0, timeout_o}, 32'd1);
      check("err_state", {29'd0, state_o}, 32'd6);
      check("err_no_req", {30'd0, ifu_req_o, lsu_req_o}, 32'd0);
      do_reset();

      push_event(K_ERR, 8);
      fetch(32'h0000_a103, 1);
      wait_lsu();
      repeat (8) begin
         lsu_ack_i = 1'b0;
         ifu_ack_i = 1'($urandom_range(0, 1));
         step();
      end
      check("mem_timeout_sticky", {31'd0, timeout_o}, 32'd1);
      do_reset();

      issue(32'h0010_0113, 1'b0, 1'b1, 1, 0);
      fetch(32'h0000_a103, 0);
      wait_lsu();
      lsu_ack_i = 1'b0;
      step();
      check("mid_mem_waiting", {31'd0, lsu_req_o}, 32'd1);
      check("pre_reset_instret", instret_o, model_instret);
      do_reset();
      issue(32'h0050_0093, 1'b0, 1'b1, 1, 0);

      n = 0;
      while (exp_q.size() != 0 && n < 20) begin
         step();
         n++;
      end
      check("queue_drained", exp_q.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/ysyx_25060170_ctrl.md
YSYX_25060170_CTRL -- requirements
Module: ysyx_25060170_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 255: max wait cycles for a memory ack in FETCH or MEM; 0 disables the timeout.
REQ-002 clk  in  1  sole clock; all state updates on the rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 ifu_req_o  out  1  instruction-fetch request to imem, level-held until ack.
REQ-005 ifu_ack_i  in  1  imem ack; ifu_rdata_i valid in the same cycle.
REQ-006 ifu_rdata_i  in  32  fetched instruction.
REQ-007 inst_o  out  32  instruction register, drives IDU inst_i.
REQ-008 is_load_i / is_store_i / is_ebreak_i  in  1 each  instruction class, decoded combinationally from inst_o.
REQ-009 reg_we_i  in  1  IDU RegW for the current instruction.
REQ-010 lsu_req_o  out  1  data-memory request, level-held until ack.
REQ-011 lsu_ack_i  in  1  dmem ack (load data or store done).
REQ-012 gpr_we_o  out  1  gated GPR write enable.
REQ-013 pc_we_o  out  1  PC update strobe, one cycle per retired instruction.
REQ-014 halt_o  out  1  sticky ebreak halt.
REQ-015 timeout_o  out  1  sticky bus-timeout error.
REQ-016 instret_o  out  32  retired-instruction counter.
REQ-017 state_o  out  3  current state, for debug and trace.

Function
REQ-018 States and encodings: IDLE=0, FETCH=1, DECODE=2, MEM=3, WB=4, HALT=5, ERR=6; code 7 unreachable and recovers to IDLE.
REQ-019 IDLE moves to FETCH unconditionally after one cycle.
REQ-020 FETCH:
- ifu_req_o=1.
- On ifu_ack_i: inst_o<=ifu_rdata_i, next state DECODE.
- Otherwise stay in FETCH.
REQ-021 DECODE lasts one cycle with no requests asserted; priority is is_ebreak_i→HALT, then (is_load_i|is_store_i)→MEM, else→WB.
REQ-022 MEM: lsu_req_o=1; on lsu_ack_i go to WB, else stay in MEM.
REQ-023 WB lasts one cycle:
- gpr_we_o=reg_we_i, pc_we_o=1.
- instret_o increments by 1, wrapping 0xFFFFFFFF→0.
- Next state FETCH.
REQ-024 gpr_we_o and pc_we_o SHALL be 0 in every state other than WB.
REQ-025 HALT: halt_o=1, all requests 0; remains in HALT until reset.
REQ-026 Timeout counter behaviour:
- Clears on entry to FETCH or MEM.
- Increments each cycle spent waiting without an ack.
- When TIMEOUT≠0 and the count reaches TIMEOUT, the next state is ERR.
REQ-027 Ack arriving in the same cycle the count reaches TIMEOUT takes precedence; no error.
REQ-028 ERR: timeout_o=1, all requests 0; remains in ERR until reset.
REQ-029 Acks outside their own state (ifu_ack_i outside FETCH, lsu_ack_i outside MEM) SHALL be ignored.
REQ-030 Latency with ack in the first request cycle: non-memory instruction 3 cycles per retire (FETCH, DECODE, WB); load/store 4 cycles. Each ack wait cycle adds 1.
REQ-031 Outputs SHALL be Moore (decoded from state). Exceptions: gpr_we_o follows reg_we_i in WB; inst_o and instret_o are registers.

Reset
REQ-032 On rst assertion, regardless of state (including mid-FETCH/MEM wait), the block SHALL immediately set:
- state=IDLE, inst_o=0, instret_o=0, timeout counter=0.
- halt_o=0, timeout_o=0, ifu_req_o=0, lsu_req_o=0, gpr_we_o=0, pc_we_o=0.
REQ-033 The first ifu_req_o SHALL assert in the second cycle after rst deassertion.

Structure
REQ-034 State encodings and state width SHALL be defined in shared package ysyx_25060170_pkg, alongside the RV32 opcode constants used by the IDU.
REQ-035 The timeout counter SHALL be a sub-module ysyx_25060170_wdt with ports clk, rst, clr, en, expired and parameter TIMEOUT; its counter width is derived from TIMEOUT.

Verification
REQ-036 addi fetched with immediate ack → FETCH, DECODE, WB on consecutive cycles; pc_we_o pulses once; gpr_we_o=1; instret_o 0→1.
REQ-037 lw: imem acks after 2 wait cycles, dmem after 3 → lsu_req_o high exactly 4 cycles; gpr_we_o=1 in WB only; 9 cycles total from FETCH entry to WB exit.
REQ-038 sw with reg_we_i=0 → gpr_we_o stays 0, pc_we_o pulses once in WB.
REQ-039 TIMEOUT=4, imem never acks → ERR entered after 4 wait cycles, timeout_o=1 sticky. Repeat with ack on the 4th cycle → DECODE, no error.
REQ-040 ebreak (0x00100073) → HALT after DECODE, halt_o=1, no pc_we_o, instret_o unchanged. rst asserted mid-MEM wait → IDLE immediately, all outputs 0, refetch starts 2 cycles after release.
